hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 79 +++++++
 tb/tb_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based stall/bubble/flush control with a HALT drain FSM.
// Define HAZARD_CTRL_FORWARD_EN to stall only on load-use against the EX entry.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_wr_en,
  input  logic [2:0] id_wr,
  input  logic       id_is_load,
  input  logic       id_halt,
  input  logic       ex_pcsel,
  output logic       stall,
  output logic       bubble,
  output logic       flush,
  output logic       halted,
  output logic [1:0] state
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;
  state_t cur, nxt;
  logic [2:0] cnt, cntNxt, sbValid, sbLoad, match;
  logic [2:0][2:0] sbReg;
  logic hazard, unusedBits;
  // entry 0 = EX, 1 = MEM, 2 = WB
  always_comb begin
    match = '0;
    for (int i = 0; i < 3; i++)
      match[i] = sbValid[i] & ((id_rs_used & (sbReg[i] == id_rs)) | (id_rt_used & (sbReg[i] == id_rt)));
  end
`ifdef HAZARD_CTRL_FORWARD_EN
  assign hazard = id_valid & match[0] & sbLoad[0];
`else
  assign hazard = id_valid & |match;
`endif
  assign unusedBits = ^{sbLoad, match};
  always_comb begin
    nxt = cur;
    cntNxt = cnt;
    flush = 1'b0;
    stall = 1'b1;
    bubble = 1'b1;
    if (cur == RUN) begin
      flush = ex_pcsel;
      stall = hazard & ~ex_pcsel;
      bubble = stall | ex_pcsel;
      cntNxt = '0;
      nxt = (id_valid & id_halt & ~stall & ~ex_pcsel) ? DRAIN : RUN;
    end else if (cur == DRAIN) begin
      cntNxt = cnt + 3'd1;
      nxt = (cnt == 3'(DRAIN_CYCLES - 1)) ? HALTED : DRAIN;
    end
    if (!rst) begin
      flush = 1'b0;
      stall = 1'b0;
      bubble = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur <= RUN;
      cnt <= '0;
      sbValid <= '0;
      sbReg <= '0;
      sbLoad <= '0;
    end else begin
      cur <= nxt;
      cnt <= cntNxt;
      sbValid <= {sbValid[1:0], id_valid & id_wr_en & ~bubble};
      sbReg <= {sbReg[1:0], id_wr};
      sbLoad <= {sbLoad[1:0], id_is_load};
    end
  assign halted = cur == HALTED;
  assign state = cur;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed vector table, hand sequences and random stimulus against a
// reference model that tracks the last three issued writers and the halt progress.
module tb_hazard_ctrl;
  localparam int DC = 3;
  logic clk = 0, rst = 0;
  logic id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_halt, ex_pcsel;
  logic [2:0] id_rs, id_rt, id_wr;
  logic stall, bubble, flush, halted;
  logic [1:0] state;
  hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rs(id_rs), .id_rt(id_rt), .id_wr_en(id_wr_en), .id_wr(id_wr), .id_is_load(id_is_load),
    .id_halt(id_halt), .ex_pcsel(ex_pcsel), .stall(stall), .bubble(bubble), .flush(flush),
    .halted(halted), .state(state)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v, rsU, rtU;
    logic [2:0] rs, rt;
    logic we;
    logic [2:0] wr;
    logic ld, hlt, pc;
    logic s, b, f;
    logic [1:0] st;
  } vec_t;
  typedef struct {
    logic v;
    logic [2:0] r;
    logic ld;
  } wr_t;
  vec_t tbl[$];
  wr_t inflight[$];
  int mMode = 0, mDrain = 0, nCmp = 0, nBad = 0;
  logic eStall, eBubble, eFlush;
  task automatic add(input logic v, rsU, rtU, input logic [2:0] rs, rt, input logic we,
                     input logic [2:0] wr, input logic ld, hlt, pc, s, b, f, input logic [1:0] st);
    vec_t x;
    x.v = v; x.rsU = rsU; x.rtU = rtU; x.rs = rs; x.rt = rt; x.we = we; x.wr = wr;
    x.ld = ld; x.hlt = hlt; x.pc = pc; x.s = s; x.b = b; x.f = f; x.st = st;
    tbl.push_back(x);
  endtask
  task automatic drive(input vec_t x);
    id_valid = x.v; id_rs_used = x.rsU; id_rt_used = x.rtU; id_rs = x.rs; id_rt = x.rt;
    id_wr_en = x.we; id_wr = x.wr; id_is_load = x.ld; id_halt = x.hlt; ex_pcsel = x.pc;
  endtask
  task automatic randIn();
    id_valid = $urandom_range(0, 3) != 0; id_rs_used = 1'($urandom); id_rt_used = 1'($urandom);
    id_rs = 3'($urandom_range(0, 3)); id_rt = 3'($urandom_range(0, 3));
    id_wr_en = 1'($urandom); id_wr = 3'($urandom_range(0, 3)); id_is_load = 1'($urandom);
    id_halt = $urandom_range(0, 24) == 0; ex_pcsel = $urandom_range(0, 5) == 0;
  endtask
  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic reads(input logic [2:0] r);
    return (id_rs_used && id_rs == r) || (id_rt_used && id_rt == r);
  endfunction
  task automatic modelOut();
    logic haz;
    haz = 0;
    foreach (inflight[i]) begin
`ifdef HAZARD_CTRL_FORWARD_EN
      if (i == 0 && inflight[i].v && inflight[i].ld && reads(inflight[i].r)) haz = 1;
`else
      if (inflight[i].v && reads(inflight[i].r)) haz = 1;
`endif
    end
    haz = haz & id_valid;
    if (mMode == 0) begin
      eFlush = ex_pcsel; eStall = haz & ~ex_pcsel; eBubble = haz | ex_pcsel;
    end else begin
      eFlush = 0; eStall = 1; eBubble = 1;
    end
  endtask
  task automatic modelStep();
    wr_t w;
    w.v = id_valid & id_wr_en & ~eBubble; w.r = id_wr; w.ld = id_is_load;
    inflight.push_front(w);
    if (inflight.size() > 3) void'(inflight.pop_back());
    if (mMode == 0 && id_valid && id_halt && !eStall && !ex_pcsel) begin
      mMode = 1; mDrain = 0;
    end else if (mMode == 1) begin
      mDrain++;
      if (mDrain == DC) mMode = 2;
    end
  endtask
  task automatic cycle(input bit useTbl, input vec_t x);
    @(negedge clk);
    modelOut();
    chk("stall", 4'(stall), 4'(eStall));
    chk("bubble", 4'(bubble), 4'(eBubble));
    chk("flush", 4'(flush), 4'(eFlush));
    chk("state", 4'(state), 4'(mMode));
    chk("halted", 4'(halted), 4'(mMode == 2));
    if (useTbl) begin
      chk("tbl_stall", 4'(stall), 4'(x.s));
      chk("tbl_bubble", 4'(bubble), 4'(x.b));
      chk("tbl_flush", 4'(flush), 4'(x.f));
      chk("tbl_state", 4'(state), 4'(x.st));
      chk("tbl_halted", 4'(halted), 4'(x.st == 2'd2));
    end
    modelStep();
    @(posedge clk);
    #1;
  endtask
  task automatic doReset();
    rst = 0;
    #1;
    chk("rst_stall", 4'(stall), 4'd0);
    chk("rst_bubble", 4'(bubble), 4'd0);
    chk("rst_flush", 4'(flush), 4'd0);
    chk("rst_state", 4'(state), 4'd0);
    chk("rst_halted", 4'(halted), 4'd0);
    inflight.delete();
    mMode = 0; mDrain = 0;
    @(posedge clk);
    #1;
    rst = 1;
  endtask
  initial begin
    vec_t z;
    z = '{default: 0};
    randIn();
    id_valid = 1; ex_pcsel = 1;
    doReset();
`ifdef HAZARD_CTRL_FORWARD_EN
    add(1,0,0,0,0,1,1,0,0,0, 0,0,0,0);
    add(1,1,0,1,0,1,3,0,0,0, 0,0,0,0);
    add(1,0,0,0,0,1,2,1,0,0, 0,0,0,0);
    add(1,0,1,0,2,1,4,0,0,0, 1,1,0,0);
    add(1,0,1,0,2,1,4,0,0,0, 0,0,0,0);
`else
    add(1,0,0,0,0,1,1,0,0,0, 0,0,0,0);
    for (int i = 0; i < 3; i++) add(1,1,0,1,0,1,3,0,0,0, 1,1,0,0);
    add(1,1,0,1,0,1,3,0,0,0, 0,0,0,0);
    add(1,0,1,0,3,1,4,0,0,1, 0,1,1,0);
    add(1,0,1,0,4,0,0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0,1,0,0,0,0, 0,0,0,0);
    add(1,1,0,0,0,0,0,0,0,0, 1,1,0,0);
    add(0,1,0,0,0,0,0,0,0,0, 0,0,0,0);
`endif
    add(1,0,0,0,0,0,0,0,1,1, 0,1,1,0);
    add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0,0,0,0,1,0, 0,0,0,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,0,0,0,0,1, 1,1,0,1);
    for (int i = 0; i < 2; i++) add(0,0,0,0,0,0,0,0,0,0, 1,1,0,2);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      cycle(1, tbl[i]);
    end
    // stale r1 sits in the scoreboard when reset hits mid-drain
    drive(z);
    doReset();
    tbl.delete();
    add(1,0,0,0,0,1,1,0,0,0, 0,0,0,0);
    add(1,0,0,0,0,0,0,0,1,0, 0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0, 1,1,0,1);
    foreach (tbl[i]) begin
      drive(tbl[i]);
      cycle(1, tbl[i]);
    end
    z.v = 1; z.rsU = 1; z.rs = 3'd1; z.pc = 1;
    drive(z);
    doReset();
    z.pc = 0;
    drive(z);
    cycle(1, z);
    for (int i = 0; i < 500; i++) begin
      randIn();
      if ($urandom_range(0, 39) == 0) doReset();
      else cycle(0, z);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
